// File: rtl/aes_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_pkg
//  Description : Shared AES-128 key-schedule definitions. Holds the cipher
//                constants, the sequencer state encoding, the round-index
//                type and the GF(2^8) helpers used by the round stage.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_key_pkg;

  localparam int AES_NR          = 10;
  localparam int AES_KEY_LENGTH  = 128;
  localparam int AES_WORD_LENGTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] round_t;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // S-box computed algebraically: multiplicative inverse as a^254
  // (which maps 0 to 0), followed by the AES affine transform.
  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);     // a^(2^k)
      inv = gf_mul(inv, p);   // accumulates a^(2+4+...+128) = a^254
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [AES_WORD_LENGTH-1:0] aes_sub_word(
      input logic [AES_WORD_LENGTH-1:0] w);
    return {aes_sbox(w[31:24]), aes_sbox(w[23:16]),
            aes_sbox(w[15:8]),  aes_sbox(w[7:0])};
  endfunction

  // Round constant for round i (1-based): x^(i-1) in GF(2^8).
  function automatic logic [7:0] aes_rcon(input logic [7:0] i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < 16; k++) begin
      if (8'(k) < i) r = gf_xtime(r);
    end
    return r;
  endfunction

endpackage : aes_key_pkg
`default_nettype wire

// File: rtl/key_expansion_round.sv
`default_nettype none
// ============================================================================
//  Module      : key_expansion_round
//  Description : One AES-128 key-expansion round with a single register
//                stage. Given the previous round key and the round number,
//                produces the next round key one cycle after i_valid.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                i_valid, i, key     - request strobe, round number, prev key
//                o_valid             - temp_schedule holds a fresh result
//                temp_schedule       - next round key
//  Revision    : 1.0  initial release
// ============================================================================
module key_expansion_round
  import aes_key_pkg::*;
#(
  parameter int KEY_LENGTH = AES_KEY_LENGTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [7:0]            i,
  input  logic [KEY_LENGTH-1:0] key,
  output logic                  o_valid,
  output logic [KEY_LENGTH-1:0] temp_schedule
);

  logic [AES_WORD_LENGTH-1:0] w_w0, w_w1, w_w2, w_w3;
  logic [AES_WORD_LENGTH-1:0] w_temp;
  logic [AES_WORD_LENGTH-1:0] w_n0, w_n1, w_n2, w_n3;

  logic                  r_valid;
  logic [KEY_LENGTH-1:0] r_sched;

  assign w_w0 = key[KEY_LENGTH-1                   -: AES_WORD_LENGTH];
  assign w_w1 = key[KEY_LENGTH-1-AES_WORD_LENGTH   -: AES_WORD_LENGTH];
  assign w_w2 = key[KEY_LENGTH-1-2*AES_WORD_LENGTH -: AES_WORD_LENGTH];
  assign w_w3 = key[KEY_LENGTH-1-3*AES_WORD_LENGTH -: AES_WORD_LENGTH];

  // SubWord(RotWord(w3)) xor Rcon
  assign w_temp = aes_sub_word({w_w3[23:0], w_w3[31:24]}) ^ {aes_rcon(i), 24'h000000};

  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_sched <= {w_n0, w_n1, w_n2, w_n3};
    end
  end

  assign o_valid       = r_valid;
  assign temp_schedule = r_sched;

endmodule : key_expansion_round
`default_nettype wire

// File: rtl/aes_key_schedule_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_schedule_sequencer
//  Description : Runs key_expansion_round for rounds 1..NR from a loaded
//                cipher key, keeps all NR+1 round keys in registers and
//                serves them through a registered random-access read port.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                start, cipher_key          - expansion request and round-0 key
//                busy, keys_ready           - expansion status
//                rd_en, rd_round            - read request and key index
//                rd_valid, rd_err, rd_key   - read response (1-cycle latency)
//  Revision    : 1.0  initial release
// ============================================================================
module aes_key_schedule_sequencer
  import aes_key_pkg::*;
#(
  parameter int KEY_LENGTH = AES_KEY_LENGTH,
  parameter int NR         = AES_NR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_LENGTH-1:0] cipher_key,
  output logic                  busy,
  output logic                  keys_ready,
  input  logic                  rd_en,
  input  logic [3:0]            rd_round,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [KEY_LENGTH-1:0] rd_key
);

  localparam round_t c_NR_IDX = round_t'(NR);

  state_t                r_state;
  round_t                r_round;
  logic                  r_busy;
  logic                  r_keys_ready;
  logic [KEY_LENGTH-1:0] r_slots [0:NR];
  logic [KEY_LENGTH-1:0] r_last_key;
  logic                  r_rd_valid;
  logic                  r_rd_err;
  logic [KEY_LENGTH-1:0] r_rd_key;

  logic                  w_accept;
  logic                  w_stage_valid;
  logic [7:0]            w_stage_round;
  logic                  w_stage_o_valid;
  logic [KEY_LENGTH-1:0] w_stage_key;
  logic                  w_round_done;
  logic                  w_rd_ok;
  round_t                w_rd_idx;

  // start is only honoured when no expansion is running
  assign w_accept      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_stage_valid = (r_state == ST_ISSUE);
  assign w_stage_round = {4'd0, r_round};
  assign w_round_done  = (r_state == ST_WAIT) && w_stage_o_valid;

  key_expansion_round #(
    .KEY_LENGTH (KEY_LENGTH)
  ) u_round (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (w_stage_valid),
    .i             (w_stage_round),
    .key           (r_last_key),
    .o_valid       (w_stage_o_valid),
    .temp_schedule (w_stage_key)
  );

  // Sequencing FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_round      <= '0;
      r_busy       <= 1'b0;
      r_keys_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_round      <= round_t'(1);
            r_keys_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_stage_o_valid) begin
            if (r_round == c_NR_IDX) begin
              r_busy       <= 1'b0;
              r_keys_ready <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_round <= r_round + round_t'(1);
              r_state <= ST_ISSUE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Key storage: plain registers, intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_accept) begin
        r_slots[0] <= cipher_key;
        r_last_key <= cipher_key;
      end else if (w_round_done) begin
        r_slots[r_round] <= w_stage_key;
        r_last_key       <= w_stage_key;
      end
    end
  end

  // Read port. keys_ready is the registered value, so a read issued in the
  // same cycle as a restarting start still sees the previous key set.
  assign w_rd_ok  = r_keys_ready && (rd_round <= c_NR_IDX);
  assign w_rd_idx = w_rd_ok ? rd_round : round_t'(0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_key   <= '0;
    end else if (rd_en) begin
      if (w_rd_ok) begin
        r_rd_valid <= 1'b1;
        r_rd_err   <= 1'b0;
        r_rd_key   <= r_slots[w_rd_idx];
      end else begin
        r_rd_valid <= 1'b0;
        r_rd_err   <= 1'b1;
        r_rd_key   <= '0;
      end
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end
  end

  assign busy       = r_busy;
  assign keys_ready = r_keys_ready;
  assign rd_valid   = r_rd_valid;
  assign rd_err     = r_rd_err;
  assign rd_key     = r_rd_key;

endmodule : aes_key_schedule_sequencer
`default_nettype wire

// File: tb/tb_aes_key_schedule_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_schedule_sequencer
//  Description : Self-checking bench for aes_key_schedule_sequencer using
//                FIPS-197 reference schedules, a read-vector table and a
//                scoreboard queue of expected read responses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_key_schedule_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         keys_ready;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic         rd_valid;
  logic         rd_err;
  logic [127:0] rd_key;

  aes_key_schedule_sequencer #(
    .KEY_LENGTH (128),
    .NR         (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rd_en      (rd_en),
    .rd_round   (rd_round),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [3:0]   rnd;
    logic         exp_valid;
    logic         exp_err;
    logic [127:0] exp_key;
  } rd_vec_t;

  rd_vec_t      sb_q[$];
  rd_vec_t      tbl[16];
  logic [127:0] a1[0:10];
  logic [127:0] zero_r10;
  int           n_vec = 0;
  int           n_bad = 0;
  int           n_cyc;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge and retire the
  // oldest pending read expectation.
  task automatic step();
    rd_vec_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("rd_valid en=%0d r=%0d", e.en, e.rnd), {127'd0, rd_valid}, {127'd0, e.exp_valid});
      chk($sformatf("rd_err en=%0d r=%0d", e.en, e.rnd), {127'd0, rd_err}, {127'd0, e.exp_err});
      chk($sformatf("rd_key en=%0d r=%0d", e.en, e.rnd), rd_key, e.exp_key);
    end
  endtask

  task automatic issue(input logic en, input logic [3:0] rnd, input logic v,
                       input logic er, input logic [127:0] k);
    rd_vec_t e;
    e.en = en; e.rnd = rnd; e.exp_valid = v; e.exp_err = er; e.exp_key = k;
    rd_en    = en;
    rd_round = rnd;
    sb_q.push_back(e);
    step();
    rd_en = 1'b0;
  endtask

  // Wait for keys_ready, counting cycles from the accepting edge (cycle 1 is
  // the cycle right after it). Optionally pulses start / issues a read mid-run.
  task automatic wait_ready(input int ignore_at, input logic [127:0] ignore_key,
                            input int rd_busy_at, output int n);
    n = 1;
    while (!keys_ready && n < 100) begin
      if (n == ignore_at) begin
        start      = 1'b1;
        cipher_key = ignore_key;
      end
      if (n == rd_busy_at) issue(1'b1, 4'd1, 1'b0, 1'b1, 128'd0);
      else step();
      start = 1'b0;
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL keys_ready timeout: got %0d cycles expected 21", n);
    end
  endtask

  task automatic expand(input logic [127:0] key, input int ignore_at,
                        input logic [127:0] ignore_key, input int rd_busy_at);
    int n;
    start      = 1'b1;
    cipher_key = key;
    step();
    start      = 1'b0;
    cipher_key = ~key;
    chk("busy after start", {127'd0, busy}, 128'd1);
    wait_ready(ignore_at, ignore_key, rd_busy_at, n);
    chk("ready latency", 128'(n), 128'd21);
    chk("busy at done", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // Read table: consecutive rounds 0..10, out-of-range, idle, then a hold.
    for (int r = 0; r <= 10; r++) tbl[r] = '{1'b1, 4'(r), 1'b1, 1'b0, a1[r]};
    tbl[11] = '{1'b1, 4'd11, 1'b0, 1'b1, 128'd0};
    tbl[12] = '{1'b1, 4'd15, 1'b0, 1'b1, 128'd0};
    tbl[13] = '{1'b0, 4'd3,  1'b0, 1'b0, 128'd0};
    tbl[14] = '{1'b1, 4'd5,  1'b1, 1'b0, a1[5]};
    tbl[15] = '{1'b0, 4'd7,  1'b0, 1'b0, a1[5]};

    reset = 1'b1; start = 1'b0; rd_en = 1'b0; rd_round = 4'd0; cipher_key = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("reset busy",       {127'd0, busy},       128'd0);
    chk("reset keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("reset rd_valid",   {127'd0, rd_valid},   128'd0);
    chk("reset rd_err",     {127'd0, rd_err},     128'd0);
    chk("reset rd_key",     rd_key,               128'd0);

    // Read before any key set exists
    issue(1'b1, 4'd0, 1'b0, 1'b1, 128'd0);

    // A.1 expansion with a read attempted while busy
    expand(a1[0], 0, 128'd0, 3);
    chk("keys_ready A.1", {127'd0, keys_ready}, 128'd1);

    foreach (tbl[j]) issue(tbl[j].en, tbl[j].rnd, tbl[j].exp_valid, tbl[j].exp_err, tbl[j].exp_key);

    // start pulsed mid-expansion with a different key must be ignored
    expand(a1[0], 5, 128'd0, 0);
    issue(1'b1, 4'd0,  1'b1, 1'b0, a1[0]);
    issue(1'b1, 4'd1,  1'b1, 1'b0, a1[1]);
    issue(1'b1, 4'd10, 1'b1, 1'b0, a1[10]);

    // Reset during WAIT of round 4 (cycle 8 after the accepting edge)
    start = 1'b1; cipher_key = a1[0];
    step();
    start = 1'b0;
    n_cyc = 1;
    while (n_cyc < 8) begin step(); n_cyc++; end
    chk("busy before reset", {127'd0, busy}, 128'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid-reset busy",       {127'd0, busy},       128'd0);
    chk("mid-reset keys_ready", {127'd0, keys_ready}, 128'd0);
    issue(1'b1, 4'd10, 1'b0, 1'b1, 128'd0);

    // Fresh all-zero key expansion
    expand(128'd0, 0, 128'd0, 0);
    issue(1'b1, 4'd10, 1'b1, 1'b0, zero_r10);

    // Back-to-back: start and a read of slot 0 in the same DONE cycle
    start = 1'b1; cipher_key = a1[0];
    issue(1'b1, 4'd0, 1'b1, 1'b0, 128'd0);
    start = 1'b0;
    chk("b2b keys_ready dropped", {127'd0, keys_ready}, 128'd0);
    chk("b2b busy",               {127'd0, busy},       128'd1);
    wait_ready(0, 128'd0, 0, n_cyc);
    chk("b2b ready latency", 128'(n_cyc), 128'd21);
    issue(1'b1, 4'd0,  1'b1, 1'b0, a1[0]);
    issue(1'b1, 4'd10, 1'b1, 1'b0, a1[10]);
    issue(1'b1, 4'd1,  1'b1, 1'b0, a1[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_aes_key_schedule_sequencer
`default_nettype wire
